// File: rtl/conv_input_ctrl.sv
// conv_input_ctrl
//
// Input-side controller for the convolution engine. Accepts the x (vector) and
// f (filter) sample streams over valid/ready handshakes. Each accepted beat is
// written straight into its storage memory at the next sequential address.
// When both memories hold a complete set, load_done is raised and further input
// is held off. It stays that way until the datapath pulses compute_done.
//
// Optional feature (define the macro to enable):
//   FILTER_HOLD_EN - the filter is loaded once after reset. compute_done clears
//                    only the x counter, so later rounds reload x only.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   s_data_in_x/s_valid_x       x sample stream from master
//   s_ready_x                   controller accepts an x sample
//   s_data_in_f/s_valid_f       f sample stream from master
//   s_ready_f                   controller accepts an f sample
//   data_x/addr_x/wr_en_x       x memory write port (SIZE_X deep)
//   data_f/addr_f/wr_en_f       f memory write port (SIZE_F deep)
//   load_done                   both memories complete; level until consumed
//   compute_done                one-cycle pulse: memories may be overwritten
module conv_input_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SIZE_X    = 64,
  parameter int unsigned LOGSIZE_X = 6,
  parameter int unsigned SIZE_F    = 8,
  parameter int unsigned LOGSIZE_F = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  // x stream
  input  logic [WIDTH-1:0]     s_data_in_x,
  input  logic                 s_valid_x,
  output logic                 s_ready_x,
  // f stream
  input  logic [WIDTH-1:0]     s_data_in_f,
  input  logic                 s_valid_f,
  output logic                 s_ready_f,
  // x memory write port
  output logic [WIDTH-1:0]     data_x,
  output logic [LOGSIZE_X-1:0] addr_x,
  output logic                 wr_en_x,
  // f memory write port
  output logic [WIDTH-1:0]     data_f,
  output logic [LOGSIZE_F-1:0] addr_f,
  output logic                 wr_en_f,
  // datapath handshake
  output logic                 load_done,
  input  logic                 compute_done
);

  typedef enum logic [0:0] {StLoad, StFull} state_e;

  localparam logic [LOGSIZE_X:0] CntXFull = (LOGSIZE_X + 1)'(SIZE_X);
  localparam logic [LOGSIZE_F:0] CntFFull = (LOGSIZE_F + 1)'(SIZE_F);

  state_e               state_q, state_d;
  logic [LOGSIZE_X:0]   cnt_x_q, cnt_x_d;
  logic [LOGSIZE_F:0]   cnt_f_q, cnt_f_d;
  logic                 acc_x, acc_f;

  // Handshake and memory write port. Ready is a function of state, counters and
  // reset only, never of valid, so there is no combinational valid->ready path.
  always_comb begin
    s_ready_x = 1'b0;
    s_ready_f = 1'b0;
    if (!reset && (state_q == StLoad)) begin
      s_ready_x = (cnt_x_q != CntXFull);
      s_ready_f = (cnt_f_q != CntFFull);
    end

    acc_x = s_valid_x & s_ready_x;
    acc_f = s_valid_f & s_ready_f;

    // Zero-latency write: the memory captures on the same edge as the handshake.
    wr_en_x = acc_x;
    wr_en_f = acc_f;
    data_x  = s_data_in_x;
    data_f  = s_data_in_f;
    // Address forced to zero during reset so a stale count never shows up.
    addr_x  = reset ? '0 : cnt_x_q[LOGSIZE_X-1:0];
    addr_f  = reset ? '0 : cnt_f_q[LOGSIZE_F-1:0];

    load_done = !reset && (state_q == StFull);
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_x_d = cnt_x_q;
    cnt_f_d = cnt_f_q;

    unique case (state_q)
      StLoad: begin
        cnt_x_d = cnt_x_q + (LOGSIZE_X + 1)'(acc_x);
        cnt_f_d = cnt_f_q + (LOGSIZE_F + 1)'(acc_f);
        // The last beats of the two streams may land on the same or different
        // edges; move to FULL on the edge where both counts are complete.
        if ((cnt_x_d == CntXFull) && (cnt_f_d == CntFFull)) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (compute_done) begin
          cnt_x_d = '0;
`ifdef FILTER_HOLD_EN
          // Filter stays resident; only reset forces it to be reloaded.
          cnt_f_d = cnt_f_q;
`else
          cnt_f_d = '0;
`endif
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      cnt_x_q <= '0;
      cnt_f_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_x_q <= cnt_x_d;
      cnt_f_q <= cnt_f_d;
    end
  end

endmodule

// File: tb/tb_conv_input_ctrl.sv
module tb_conv_input_ctrl;

  localparam int WIDTH     = 16;
  localparam int SIZE_X    = 64;
  localparam int LOGSIZE_X = 6;
  localparam int SIZE_F    = 8;
  localparam int LOGSIZE_F = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [WIDTH-1:0]     s_data_in_x, s_data_in_f;
  logic                 s_valid_x, s_valid_f, s_ready_x, s_ready_f;
  logic [WIDTH-1:0]     data_x, data_f;
  logic [LOGSIZE_X-1:0] addr_x;
  logic [LOGSIZE_F-1:0] addr_f;
  logic                 wr_en_x, wr_en_f, load_done, compute_done;

  conv_input_ctrl #(
    .WIDTH(WIDTH), .SIZE_X(SIZE_X), .LOGSIZE_X(LOGSIZE_X),
    .SIZE_F(SIZE_F), .LOGSIZE_F(LOGSIZE_F)
  ) dut (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .data_x(data_x), .addr_x(addr_x), .wr_en_x(wr_en_x),
    .data_f(data_f), .addr_f(addr_f), .wr_en_f(wr_en_f),
    .load_done(load_done), .compute_done(compute_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: how many samples of each stream the current set holds,
  // and whether the set is complete and waiting for the datapath.
  int nx = 0;
  int nf = 0;
  bit full = 1'b0;
  logic [WIDTH-1:0] exp_x[$];
  logic [WIDTH-1:0] exp_f[$];
  // Memory images built from the DUT write ports.
  logic [WIDTH-1:0] mem_x[SIZE_X];
  logic [WIDTH-1:0] mem_f[SIZE_F];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model.
  task automatic step(input bit vx, input logic [WIDTH-1:0] dx, input bit vf,
                      input logic [WIDTH-1:0] df, input bit cd, input bit rst);
    bit ex_rx, ex_rf, ex_wx, ex_wf;
    @(negedge clk);
    reset = rst; compute_done = cd;
    s_valid_x = vx; s_data_in_x = dx;
    s_valid_f = vf; s_data_in_f = df;
    #1;
    ex_rx = !rst && !full && (nx < SIZE_X);
    ex_rf = !rst && !full && (nf < SIZE_F);
    ex_wx = vx && ex_rx;
    ex_wf = vf && ex_rf;
    chk("ready_x", 32'(s_ready_x), 32'(ex_rx));
    chk("ready_f", 32'(s_ready_f), 32'(ex_rf));
    chk("wr_en_x", 32'(wr_en_x), 32'(ex_wx));
    chk("wr_en_f", 32'(wr_en_f), 32'(ex_wf));
    chk("load_done", 32'(load_done), 32'(!rst && full));
    if (ex_wx) begin
      chk("addr_x", 32'(addr_x), 32'(nx));
      chk("data_x", 32'(data_x), 32'(dx));
    end
    if (ex_wf) begin
      chk("addr_f", 32'(addr_f), 32'(nf));
      chk("data_f", 32'(data_f), 32'(df));
    end
    if (rst) begin
      chk("addr_x_rst", 32'(addr_x), 32'd0);
      chk("addr_f_rst", 32'(addr_f), 32'd0);
    end
    if (wr_en_x === 1'b1) mem_x[addr_x] = data_x;
    if (wr_en_f === 1'b1) mem_f[addr_f] = data_f;
    @(posedge clk);
    if (rst) begin
      nx = 0; nf = 0; full = 1'b0;
      exp_x.delete(); exp_f.delete();
    end else if (full) begin
      if (cd) begin
        nx = 0;
`ifndef FILTER_HOLD_EN
        nf = 0;
`endif
        full = 1'b0;
      end
    end else begin
      if (ex_wx) begin nx++; exp_x.push_back(dx); end
      if (ex_wf) begin nf++; exp_f.push_back(df); end
      if (nx == SIZE_X && nf == SIZE_F) begin
        full = 1'b1;
        // Every sample of the set must sit at its arrival index.
        for (int i = 0; i < exp_x.size(); i++) chk("mem_x", 32'(mem_x[i]), 32'(exp_x[i]));
        for (int i = 0; i < exp_f.size(); i++) chk("mem_f", 32'(mem_f[i]), 32'(exp_f[i]));
        exp_x.delete(); exp_f.delete();
      end
    end
  endtask

  // Load one complete set. mode 0: valids always high, data = 1..N.
  // mode 1: 50% valids, last f beat withheld until x is complete. mode 2: 50% valids.
  // cd_at pulses compute_done on that cycle (LOAD phase: must be ignored).
  task automatic run_load(input int mode, input int cd_at);
    int cyc = 0;
    bit vx, vf;
    logic [WIDTH-1:0] dx, df;
    while (!full && cyc < 600) begin
      if (mode == 0) begin
        vx = 1'b1; vf = 1'b1;
        dx = WIDTH'(nx + 1); df = WIDTH'(nf + 1);
      end else begin
        vx = $urandom_range(1, 0) == 1;
        vf = $urandom_range(1, 0) == 1;
        dx = WIDTH'($urandom); df = WIDTH'($urandom);
        if (mode == 1 && nf == SIZE_F - 1 && nx < SIZE_X) vf = 1'b0;
      end
      step(vx, dx, vf, df, cyc == cd_at, 1'b0);
      cyc++;
    end
    @(negedge clk); #1;
    chk("load_done_end", 32'(load_done), 32'd1);
  endtask

  task automatic hold_full(input int n);
    for (int i = 0; i < n; i++) step(1'b1, WIDTH'($urandom), 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; compute_done = 1'b0;
    s_valid_x = 1'b0; s_valid_f = 1'b0;
    s_data_in_x = '0; s_data_in_f = '0;

    // Reset: readys, writes, addresses and load_done all low.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1234, 1'b1, 16'h5678, 1'b0, 1'b1);

    // Back-to-back stream, then FULL with valids held high, then release.
    run_load(0, -1);
    hold_full(20);

    // Random gaps, filter finishing last; compute_done in LOAD at cycle 10.
    run_load(1, 10);
    hold_full(3);

    // Reset after 30 x and 4 f beats; partial data discarded.
    for (int i = 0; i < 60 && (nx < 30 || nf < 4); i++)
      step(nx < 30, WIDTH'($urandom), nf < 4, WIDTH'($urandom), 1'b0, 1'b0);
    chk("partial_x", 32'(nx), 32'd30);
    step(1'b1, WIDTH'($urandom), 1'b1, WIDTH'($urandom), 1'b0, 1'b1);
    step(1'b1, WIDTH'($urandom), 1'b1, WIDTH'($urandom), 1'b0, 1'b1);
    run_load(2, 5);
    hold_full(2);

    // Further rounds (with FILTER_HOLD_EN these reload x only).
    run_load(2, -1);
    hold_full(1);
    run_load(1, 0);

    // Reset from FULL, then a fresh complete load including the filter.
    step(1'b1, WIDTH'($urandom), 1'b1, WIDTH'($urandom), 1'b1, 1'b1);
    run_load(2, -1);
    hold_full(2);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_input_ctrl.md
# conv_input_ctrl

Input-side controller for the convolution engine. Accepts the vector (x) and filter (f) sample streams from the master over valid/ready handshakes and generates the address, write-enable and data for the two parallel-output storage memories (x memory SIZE_X deep, f memory SIZE_F deep). When both memories are full it raises `load_done` to the datapath and holds off further input until the datapath returns `compute_done`.

## Interface
- `WIDTH`, 16, sample width in bits (signed)
- `SIZE_X`, 64, x memory depth (samples per vector)
- `LOGSIZE_X`, 6, clog2(SIZE_X)
- `SIZE_F`, 8, f memory depth (filter taps)
- `LOGSIZE_F`, 3, clog2(SIZE_F)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `s_data_in_x`  in  WIDTH  x sample from master
- `s_valid_x`  in  1  x sample valid
- `s_ready_x`  out  1  controller accepts an x sample
- `s_data_in_f`  in  WIDTH  f sample from master
- `s_valid_f`  in  1  f sample valid
- `s_ready_f`  out  1  controller accepts an f sample
- `data_x` / `addr_x` / `wr_en_x`  out  WIDTH / LOGSIZE_X / 1  x memory write port
- `data_f` / `addr_f` / `wr_en_f`  out  WIDTH / LOGSIZE_F / 1  f memory write port
- `load_done`  out  1  both memories hold a complete set; level, held until consumed
- `compute_done`  in  1  one-cycle pulse from datapath: memories may be overwritten

## Operation
- State machine: LOAD, FULL. Reset state LOAD.
- Counters `cnt_x` (LOGSIZE_X+1 bits, 0..SIZE_X) and `cnt_f` (LOGSIZE_F+1 bits, 0..SIZE_F); reset to 0.
- LOAD: `s_ready_x = (cnt_x != SIZE_X)`, `s_ready_f = (cnt_f != SIZE_F)`; streams are independent and may be accepted in the same cycle.
- Beat accepted when valid && ready: `wr_en_* = 1`, `addr_* = cnt_*[LOGSIZE-1:0]`, `data_* = s_data_in_*` (combinational passthrough); counter increments on that edge. Writes go to addresses 0,1,2,… in arrival order.
- LOAD -> FULL on the edge where `cnt_x == SIZE_X` and `cnt_f == SIZE_F` become true together (last beats may land in the same cycle or different cycles).
- FULL: both readys low, no writes, `load_done = 1`. On `compute_done = 1`: counters cleared, -> LOAD.
- `compute_done` in LOAD is ignored.
- No wrap-around: a full counter saturates via ready=0; excess master data simply stalls.

## Timing
- All outputs low/zero during and directly after reset: readys 0 while `reset` is high, `wr_en_*` 0, `addr_*` 0, `load_done` 0.
- Write latency 0: memory captures data on the same edge as the handshake.
- `load_done` rises the cycle after the final accepted beat (registered from state).
- After `compute_done` pulse, readys return high the next cycle (one-cycle turnaround).
- Reset mid-load or in FULL: all partial data discarded, counters 0, state LOAD next cycle; memory contents are not cleared and are don't-care.
- Ready never depends on valid in the same cycle (no combinational valid->ready path).

## Configuration
- `FILTER_HOLD_EN`: when defined, the filter is loaded once after reset. On `compute_done`, only `cnt_x` clears; `cnt_f` stays SIZE_F and `s_ready_f` stays low, so subsequent rounds reload x only. Reset clears `cnt_f` and forces a new filter load.
- Without it: both counters clear on every `compute_done` and both memories reload each round.

## Test plan
- Reset, then stream x = 1..64 and f = 1..8 with valid always high -> addr_x 0..63 / addr_f 0..7 written in order, `load_done` high cycle after 64th x beat, both readys low.
- Random valid gaps on both streams (50% duty), last f beat arrives after last x -> no write while valid low, `load_done` only after last f beat.
- In FULL, hold valids high for 20 cycles, then pulse `compute_done` -> zero writes during FULL, readys high next cycle, second round writes start at address 0.
- Assert `reset` after 30 x and 4 f beats -> readys low during reset, next round first write at addr 0, `load_done` requires full 64+8 beats.
- `compute_done` pulsed during LOAD at cycle 10 -> no effect on counters or state.
- `FILTER_HOLD_EN` defined: two rounds -> round 2 `s_ready_f` stays 0, only 64 x beats needed for `load_done`; reset then restores f loading.
